// File: rtl/perf_pkg.sv
// Shared types for the pipeline performance-counter unit.
// Holds the run-state encoding and the event-strobe index map used by Pipeline_top.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int EVT_RETIRE = 0;
  localparam int EVT_BRANCH = 1;
  localparam int EVT_STALL  = 2;
  localparam int EVT_FLUSH  = 3;

  // All-ones value of a counter of width w, used for saturation detection.
  function automatic logic [63:0] sat_value(input int w);
    logic [63:0] v;
    v = {64{1'b0}};
    for (int i = 0; i < 64; i++) begin
      if (i < w) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky overflow flag.
// clr has priority, hold freezes the count, inc advances it by one.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         hold,
  output logic [W-1:0] q,
  output logic         sat
);

  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ALL1 = {W{1'b1}};

  logic [W-1:0] q_r;
  logic         sat_r;

  // Count register; an increment attempted at all-ones holds and flags overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r   <= ZERO;
      sat_r <= 1'b0;
    end else if (clr) begin
      q_r   <= ZERO;
      sat_r <= 1'b0;
    end else if (!hold && inc) begin
      if (q_r == ALL1) begin
        sat_r <= 1'b1;
      end else begin
        q_r <= q_r + ONE;
      end
    end else begin
      q_r   <= q_r;
      sat_r <= sat_r;
    end
  end

  assign q   = q_r;
  assign sat = sat_r;

endmodule

// File: rtl/pipe_perf_counters.sv
// Cycle/event performance counters with a programmable run limit and a
// snapshot bank read through a combinational mux.
module pipe_perf_counters #(
  parameter int CNT_W   = 32,
  parameter int NUM_EVT = 4,
  parameter int SEL_W   = $clog2(NUM_EVT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clr,
  input  logic               freeze,
  input  logic [NUM_EVT-1:0] evt,
  input  logic [CNT_W-1:0]   cycle_limit,
  input  logic               snap,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic               running,
  output logic               done,
  output logic [NUM_EVT:0]   ovf
);

  import perf_pkg::*;

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_r;
  state_e             state_nxt_s;
  logic [CNT_W-1:0]   limit_r;
  logic [CNT_W-1:0]   live_s   [0:NUM_EVT];
  logic [CNT_W-1:0]   shadow_r [0:NUM_EVT];
  logic [NUM_EVT:0]   sat_s;
  logic [NUM_EVT:0]   inc_s;
  logic               cnt_clr_s;
  logic               cnt_hold_s;
  logic               limit_hit_s;
  logic [CNT_W-1:0]   rd_data_s;

  // Slot 0 counts every enabled cycle; slot i+1 counts event strobe i.
  assign inc_s      = {evt, 1'b1};
  assign cnt_clr_s  = clr | start;
  assign cnt_hold_s = (state_r != RUN) | freeze;
  // True when this cycle's increment lands the cycle counter on a nonzero limit.
  assign limit_hit_s = (limit_r != ZERO) && ((live_s[0] + ONE) == limit_r);

  for (genvar g = 0; g <= NUM_EVT; g++) begin : g_cnt
    sat_counter #(
      .W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr_s),
      .inc  (inc_s[g]),
      .hold (cnt_hold_s),
      .q    (live_s[g]),
      .sat  (sat_s[g])
    );
  end

  // Next-state logic: clr beats start, start (re)launches from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (clr) begin
      state_nxt_s = IDLE;
    end else if (start) begin
      state_nxt_s = RUN;
    end else begin
      case (state_r)
        IDLE: state_nxt_s = IDLE;
        RUN: begin
          if (!freeze && limit_hit_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end
        DONE:    state_nxt_s = DONE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Run limit, captured only when a run is launched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      limit_r <= ZERO;
    end else if (clr) begin
      limit_r <= ZERO;
    end else if (start) begin
      limit_r <= cycle_limit;
    end else begin
      limit_r <= limit_r;
    end
  end

  // Shadow bank: snap copies the pre-increment live values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= NUM_EVT; i++) begin
        shadow_r[i] <= ZERO;
      end
    end else if (clr) begin
      for (int i = 0; i <= NUM_EVT; i++) begin
        shadow_r[i] <= ZERO;
      end
    end else if (snap) begin
      for (int i = 0; i <= NUM_EVT; i++) begin
        shadow_r[i] <= live_s[i];
      end
    end else begin
      for (int i = 0; i <= NUM_EVT; i++) begin
        shadow_r[i] <= shadow_r[i];
      end
    end
  end

  // Read mux; out-of-range selects read as zero.
  always_comb begin
    rd_data_s = ZERO;
    for (int i = 0; i <= NUM_EVT; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_data_s = shadow_r[i];
      end else begin
        rd_data_s = rd_data_s;
      end
    end
  end

  assign rd_data = rd_data_s;
  assign running = (state_r == RUN);
  assign done    = (state_r == DONE);
  assign ovf     = sat_s;

endmodule

// File: tb/tb_pipe_perf_counters.sv
// Directed self-checking bench for pipe_perf_counters: a 32-bit instance for
// the run/limit/snapshot behaviour and an 8-bit instance for saturation.
module tb_pipe_perf_counters;

  logic        clk;
  logic        rst;
  logic        start, clr, freeze, snap;
  logic [3:0]  evt;
  logic [31:0] cycle_limit;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic        running, done;
  logic [4:0]  ovf;

  logic        s_start, s_clr, s_freeze, s_snap;
  logic [3:0]  s_evt;
  logic [7:0]  s_cycle_limit;
  logic [2:0]  s_rd_sel;
  logic [7:0]  s_rd_data;
  logic        s_running, s_done;
  logic [4:0]  s_ovf;

  int n_checks;
  int n_fail;

  pipe_perf_counters #(.CNT_W(32), .NUM_EVT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .freeze(freeze),
    .evt(evt), .cycle_limit(cycle_limit), .snap(snap), .rd_sel(rd_sel),
    .rd_data(rd_data), .running(running), .done(done), .ovf(ovf)
  );

  pipe_perf_counters #(.CNT_W(8), .NUM_EVT(4)) dut8 (
    .clk(clk), .rst(rst), .start(s_start), .clr(s_clr), .freeze(s_freeze),
    .evt(s_evt), .cycle_limit(s_cycle_limit), .snap(s_snap), .rd_sel(s_rd_sel),
    .rd_data(s_rd_data), .running(s_running), .done(s_done), .ovf(s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input logic [31:0] lim);
    cycle_limit = lim;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_snap();
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
  endtask

  task automatic test_reset();
    tick(2);
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      n_checks++;
      if (rd_data !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_rd_data sel=%0d got=%0d exp=0", i, rd_data);
      end
    end
    n_checks++;
    if ({running, done, ovf} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_status got run=%b done=%b ovf=%b exp all 0", running, done, ovf);
    end
    rst = 1'b1;
    tick(2);
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle running=%b exp=0", running);
    end
  endtask

  task automatic test_limit();
    launch(32'd100);
    n_checks++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL limit_running got=%b exp=1", running);
    end
    tick(99);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_early_done got=%b exp=0 after 99 cycles", done);
    end
    tick(1);
    n_checks++;
    if ({running, done} !== 2'b01) begin
      n_fail++;
      $display("FAIL limit_done got run=%b done=%b exp run=0 done=1", running, done);
    end
    tick(3);
    do_snap();
    rd_sel = 3'd0;
    #1;
    n_checks++;
    if (rd_data !== 32'd100) begin
      n_fail++;
      $display("FAIL limit_cycles got=%0d exp=100", rd_data);
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL limit_done_sticky got=%b exp=1", done);
    end
  endtask

  task automatic test_events();
    logic [31:0] exp_evt [0:4];
    exp_evt[0] = 32'd10;
    exp_evt[1] = 32'd10;
    exp_evt[2] = 32'd0;
    exp_evt[3] = 32'd10;
    exp_evt[4] = 32'd0;
    launch(32'd0);
    evt = 4'b0101;
    tick(10);
    evt = 4'b0000;
    do_snap();
    for (int i = 0; i < 5; i++) begin
      rd_sel = 3'(i);
      #1;
      n_checks++;
      if (rd_data !== exp_evt[i]) begin
        n_fail++;
        $display("FAIL events_sel%0d got=%0d exp=%0d", i, rd_data, exp_evt[i]);
      end
    end
    rd_sel = 3'd5;
    #1;
    n_checks++;
    if (rd_data !== 32'd0) begin
      n_fail++;
      $display("FAIL events_oob5 got=%0d exp=0", rd_data);
    end
    rd_sel = 3'd7;
    #1;
    n_checks++;
    if (rd_data !== 32'd0) begin
      n_fail++;
      $display("FAIL events_oob7 got=%0d exp=0", rd_data);
    end
    n_checks++;
    if (ovf !== 5'd0) begin
      n_fail++;
      $display("FAIL events_ovf got=%b exp=00000", ovf);
    end
  endtask

  task automatic test_snap_evt();
    evt  = 4'b0001;
    snap = 1'b1;
    tick(1);
    evt  = 4'b0000;
    snap = 1'b0;
    rd_sel = 3'd1;
    #1;
    n_checks++;
    if (rd_data !== 32'd10) begin
      n_fail++;
      $display("FAIL snap_pre_incr got=%0d exp=10", rd_data);
    end
    do_snap();
    #1;
    n_checks++;
    if (rd_data !== 32'd11) begin
      n_fail++;
      $display("FAIL snap_post_incr got=%0d exp=11", rd_data);
    end
  endtask

  task automatic test_restart();
    launch(32'd3);
    tick(2);
    n_checks++;
    if ({running, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL restart_mid got run=%b done=%b exp run=1 done=0", running, done);
    end
    tick(1);
    n_checks++;
    if ({running, done} !== 2'b01) begin
      n_fail++;
      $display("FAIL restart_done got run=%b done=%b exp run=0 done=1", running, done);
    end
    do_snap();
    rd_sel = 3'd0;
    #1;
    n_checks++;
    if (rd_data !== 32'd3) begin
      n_fail++;
      $display("FAIL restart_cycles got=%0d exp=3", rd_data);
    end
  endtask

  task automatic test_freeze();
    launch(32'd20);
    tick(8);
    freeze = 1'b1;
    tick(5);
    freeze = 1'b0;
    tick(11);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_early_done got=%b exp=0", done);
    end
    tick(1);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL freeze_done got=%b exp=1 after 25 cycles", done);
    end
    do_snap();
    rd_sel = 3'd0;
    #1;
    n_checks++;
    if (rd_data !== 32'd20) begin
      n_fail++;
      $display("FAIL freeze_cycles got=%0d exp=20", rd_data);
    end
  endtask

  task automatic test_clr_start();
    launch(32'd0);
    evt = 4'b1111;
    tick(5);
    do_snap();
    clr   = 1'b1;
    start = 1'b1;
    tick(1);
    clr   = 1'b0;
    start = 1'b0;
    evt   = 4'b0000;
    n_checks++;
    if ({running, done, ovf} !== 7'd0) begin
      n_fail++;
      $display("FAIL clr_start_status got run=%b done=%b ovf=%b exp all 0", running, done, ovf);
    end
    rd_sel = 3'd2;
    #1;
    n_checks++;
    if (rd_data !== 32'd0) begin
      n_fail++;
      $display("FAIL clr_shadow got=%0d exp=0", rd_data);
    end
    evt = 4'b1111;
    tick(3);
    evt = 4'b0000;
    do_snap();
    for (int i = 0; i < 5; i++) begin
      rd_sel = 3'(i);
      #1;
      n_checks++;
      if (rd_data !== 32'd0) begin
        n_fail++;
        $display("FAIL clr_idle_hold sel=%0d got=%0d exp=0", i, rd_data);
      end
    end
  endtask

  task automatic test_saturation();
    s_cycle_limit = 8'd0;
    s_start = 1'b1;
    tick(1);
    s_start = 1'b0;
    s_evt = 4'b0001;
    tick(300);
    s_evt = 4'b0000;
    s_snap = 1'b1;
    tick(1);
    s_snap = 1'b0;
    s_rd_sel = 3'd1;
    #1;
    n_checks++;
    if (s_rd_data !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_evt0 got=%0d exp=255", s_rd_data);
    end
    s_rd_sel = 3'd0;
    #1;
    n_checks++;
    if (s_rd_data !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_cycles got=%0d exp=255", s_rd_data);
    end
    n_checks++;
    if (s_ovf !== 5'b00011) begin
      n_fail++;
      $display("FAIL sat_ovf got=%b exp=00011", s_ovf);
    end
    n_checks++;
    if ({s_running, s_done} !== 2'b10) begin
      n_fail++;
      $display("FAIL sat_state got run=%b done=%b exp run=1 done=0", s_running, s_done);
    end
  endtask

  task automatic test_async_reset();
    launch(32'd0);
    tick(36);
    do_snap();
    rd_sel = 3'd0;
    #1;
    n_checks++;
    if (rd_data !== 32'd36) begin
      n_fail++;
      $display("FAIL arst_pre_shadow got=%0d exp=36", rd_data);
    end
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({running, done, ovf, rd_data} !== 39'd0) begin
      n_fail++;
      $display("FAIL arst_immediate got run=%b done=%b ovf=%b rd=%0d exp all 0", running, done, ovf, rd_data);
    end
    n_checks++;
    if ({s_running, s_ovf} !== 6'd0) begin
      n_fail++;
      $display("FAIL arst_small got run=%b ovf=%b exp all 0", s_running, s_ovf);
    end
    tick(2);
    rst = 1'b1;
    tick(4);
    n_checks++;
    if ({running, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL arst_stay_idle got run=%b done=%b exp 0 0", running, done);
    end
    do_snap();
    #1;
    n_checks++;
    if (rd_data !== 32'd0) begin
      n_fail++;
      $display("FAIL arst_counters got=%0d exp=0", rd_data);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    start = 1'b0; clr = 1'b0; freeze = 1'b0; snap = 1'b0;
    evt = 4'b0000; cycle_limit = 32'd0; rd_sel = 3'd0;
    s_start = 1'b0; s_clr = 1'b0; s_freeze = 1'b0; s_snap = 1'b0;
    s_evt = 4'b0000; s_cycle_limit = 8'd0; s_rd_sel = 3'd0;
    test_reset();
    test_limit();
    test_events();
    test_snap_evt();
    test_restart();
    test_freeze();
    test_clr_start();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
